// File: rtl/ctrl_ext_exmem_pkg.sv
// Shared definitions for the ID-stage decoder/extender and the EX/MEM register.
// Contents: MIPS opcode/funct values, extender and ALU op encodings, and the
// bit positions of the packed control bundle {jump, branch, mem_read,
// mem_to_reg, mem_write, reg_write}.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_ZERO2 = 2'b11
    } ext_op_e;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SLT = 4'd5
    } alu_op_e;

    localparam int CTRL_W          = 6;
    localparam int CTRL_JUMP       = 5;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_REG_WRITE  = 0;

endpackage

// File: rtl/exmem_reg.sv
// EX/MEM pipeline register.
// Ports: clk, rst (sync, active-high), flush (sync clear), wr (load enable),
// in_* (EX-stage values), and the registered copies pc, reg_dst, alu_result,
// zero, store_data, ctrl. Priority: rst, then flush, then wr, else hold.
module exmem_reg
    import ctrl_pkg::*;
#(
    parameter int PC_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [4:0]        in_reg_dst,
    input  logic [31:0]       in_alu_result,
    input  logic              in_zero,
    input  logic [31:0]       in_store_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [PC_W-1:0]   pc,
    output logic [4:0]        reg_dst,
    output logic [31:0]       alu_result,
    output logic              zero,
    output logic [31:0]       store_data,
    output logic [CTRL_W-1:0] ctrl
);

    logic [PC_W-1:0]   pc_q;
    logic [4:0]        reg_dst_q;
    logic [31:0]       alu_result_q;
    logic              zero_q;
    logic [31:0]       store_data_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Flush produces exactly the reset state so a squashed slot is a clean bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pc_q         <= '0;
            reg_dst_q    <= '0;
            alu_result_q <= '0;
            zero_q       <= 1'b0;
            store_data_q <= '0;
            ctrl_q       <= '0;
        end else if (wr) begin
            pc_q         <= in_pc;
            reg_dst_q    <= in_reg_dst;
            alu_result_q <= in_alu_result;
            zero_q       <= in_zero;
            store_data_q <= in_store_data;
            ctrl_q       <= in_ctrl;
        end
    end

    assign pc         = pc_q;
    assign reg_dst    = reg_dst_q;
    assign alu_result = alu_result_q;
    assign zero       = zero_q;
    assign store_data = store_data_q;
    assign ctrl       = ctrl_q;

endmodule

// File: rtl/ctrl_ext_exmem.sv
// ID-stage control decoder + immediate extender, and the EX/MEM register.
// Ports: opcode/funct/imm16 in -> c_* controls, ext_op, alu_op, imm32 out
// (combinational); clk/rst/flush/wr and in_* -> registered pc, reg_dst,
// alu_result, zero, store_data, ctrl, plus pc_go for the IF-stage PC mux.
module ctrl_ext_exmem
    import ctrl_pkg::*;
#(
    parameter int PC_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm16,
    output logic              c_jump,
    output logic              c_reg_dst,
    output logic              c_branch,
    output logic              c_mem_read,
    output logic              c_mem_to_reg,
    output logic              c_mem_write,
    output logic              c_reg_write,
    output logic              c_alu_src,
    output logic [1:0]        ext_op,
    output logic [3:0]        alu_op,
    output logic [31:0]       imm32,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [4:0]        in_reg_dst,
    input  logic [31:0]       in_alu_result,
    input  logic              in_zero,
    input  logic [31:0]       in_store_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [PC_W-1:0]   pc,
    output logic [4:0]        reg_dst,
    output logic [31:0]       alu_result,
    output logic              zero,
    output logic [31:0]       store_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic              pc_go
);

    always_comb begin
        c_jump       = 1'b0;
        c_reg_dst    = 1'b0;
        c_branch     = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_to_reg = 1'b0;
        c_mem_write  = 1'b0;
        c_reg_write  = 1'b0;
        c_alu_src    = 1'b0;
        ext_op       = EXT_ZERO;
        alu_op       = ALU_NOP;
        case (opcode)
            OP_RTYPE: begin
                // Unlisted functs (incl. sll/nop) stay an all-zero bubble.
                case (funct)
                    FN_ADD, FN_ADDU: begin c_reg_dst = 1'b1; c_reg_write = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB, FN_SUBU: begin c_reg_dst = 1'b1; c_reg_write = 1'b1; alu_op = ALU_SUB; end
                    FN_AND:          begin c_reg_dst = 1'b1; c_reg_write = 1'b1; alu_op = ALU_AND; end
                    FN_OR:           begin c_reg_dst = 1'b1; c_reg_write = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT:          begin c_reg_dst = 1'b1; c_reg_write = 1'b1; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                c_reg_write = 1'b1; c_alu_src = 1'b1; ext_op = EXT_SIGN; alu_op = ALU_ADD;
            end
            OP_ANDI: begin
                c_reg_write = 1'b1; c_alu_src = 1'b1; ext_op = EXT_ZERO; alu_op = ALU_AND;
            end
            OP_ORI: begin
                c_reg_write = 1'b1; c_alu_src = 1'b1; ext_op = EXT_ZERO; alu_op = ALU_OR;
            end
            OP_LUI: begin
                // rs is $0 for lui, so ADD passes the shifted immediate through.
                c_reg_write = 1'b1; c_alu_src = 1'b1; ext_op = EXT_UPPER; alu_op = ALU_ADD;
            end
            OP_LW: begin
                c_mem_read = 1'b1; c_mem_to_reg = 1'b1; c_reg_write = 1'b1; c_alu_src = 1'b1;
                ext_op = EXT_SIGN; alu_op = ALU_ADD;
            end
            OP_SW: begin
                c_mem_write = 1'b1; c_alu_src = 1'b1; ext_op = EXT_SIGN; alu_op = ALU_ADD;
            end
            OP_BEQ: begin
                c_branch = 1'b1; ext_op = EXT_SIGN; alu_op = ALU_SUB;
            end
            OP_J: begin
                c_jump = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ext_op_e'(ext_op))
            EXT_SIGN:  imm32 = {{16{imm16[15]}}, imm16};
            EXT_UPPER: imm32 = {imm16, 16'h0000};
            default:   imm32 = {16'h0000, imm16};
        endcase
    end

    exmem_reg #(
        .PC_W (PC_W)
    ) u_exmem_reg (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .wr            (wr),
        .in_pc         (in_pc),
        .in_reg_dst    (in_reg_dst),
        .in_alu_result (in_alu_result),
        .in_zero       (in_zero),
        .in_store_data (in_store_data),
        .in_ctrl       (in_ctrl),
        .pc            (pc),
        .reg_dst       (reg_dst),
        .alu_result    (alu_result),
        .zero          (zero),
        .store_data    (store_data),
        .ctrl          (ctrl)
    );

    // Redirect is decided in MEM from registered fields only.
    assign pc_go = (ctrl[CTRL_BRANCH] & zero) | ctrl[CTRL_JUMP];

endmodule

// File: tb/tb_ctrl_ext_exmem.sv
module tb_ctrl_ext_exmem;

    logic        clk = 1'b0;
    logic        rst, flush, wr;
    logic [5:0]  opcode, funct;
    logic [15:0] imm16;
    logic        c_jump, c_reg_dst, c_branch, c_mem_read, c_mem_to_reg, c_mem_write, c_reg_write, c_alu_src;
    logic [1:0]  ext_op;
    logic [3:0]  alu_op;
    logic [31:0] imm32;
    logic [29:0] in_pc;
    logic [4:0]  in_reg_dst;
    logic [31:0] in_alu_result;
    logic        in_zero;
    logic [31:0] in_store_data;
    logic [5:0]  in_ctrl;
    logic [29:0] pc;
    logic [4:0]  reg_dst;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] store_data;
    logic [5:0]  ctrl;
    logic        pc_go;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_ext_exmem #(.PC_W(30)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr(wr),
        .opcode(opcode), .funct(funct), .imm16(imm16),
        .c_jump(c_jump), .c_reg_dst(c_reg_dst), .c_branch(c_branch), .c_mem_read(c_mem_read),
        .c_mem_to_reg(c_mem_to_reg), .c_mem_write(c_mem_write), .c_reg_write(c_reg_write),
        .c_alu_src(c_alu_src), .ext_op(ext_op), .alu_op(alu_op), .imm32(imm32),
        .in_pc(in_pc), .in_reg_dst(in_reg_dst), .in_alu_result(in_alu_result), .in_zero(in_zero),
        .in_store_data(in_store_data), .in_ctrl(in_ctrl),
        .pc(pc), .reg_dst(reg_dst), .alu_result(alu_result), .zero(zero),
        .store_data(store_data), .ctrl(ctrl), .pc_go(pc_go)
    );

    // Decoder reference: an instruction table.
    // bits = {jump, reg_dst, branch, mem_read, mem_to_reg, mem_write, reg_write, alu_src, ext[1:0], alu[3:0]}
    typedef struct {
        logic [5:0]  op;
        logic        use_fn;
        logic [5:0]  fn;
        logic [13:0] bits;
    } dec_ent_t;

    dec_ent_t tbl [17];

    initial begin
        tbl[0]  = '{6'b000000, 1'b1, 6'b100000, 14'b01000010_00_0001};
        tbl[1]  = '{6'b000000, 1'b1, 6'b100001, 14'b01000010_00_0001};
        tbl[2]  = '{6'b000000, 1'b1, 6'b100010, 14'b01000010_00_0010};
        tbl[3]  = '{6'b000000, 1'b1, 6'b100011, 14'b01000010_00_0010};
        tbl[4]  = '{6'b000000, 1'b1, 6'b100100, 14'b01000010_00_0011};
        tbl[5]  = '{6'b000000, 1'b1, 6'b100101, 14'b01000010_00_0100};
        tbl[6]  = '{6'b000000, 1'b1, 6'b101010, 14'b01000010_00_0101};
        tbl[7]  = '{6'b001000, 1'b0, 6'b000000, 14'b00000011_01_0001};
        tbl[8]  = '{6'b001001, 1'b0, 6'b000000, 14'b00000011_01_0001};
        tbl[9]  = '{6'b001100, 1'b0, 6'b000000, 14'b00000011_00_0011};
        tbl[10] = '{6'b001101, 1'b0, 6'b000000, 14'b00000011_00_0100};
        tbl[11] = '{6'b001111, 1'b0, 6'b000000, 14'b00000011_10_0001};
        tbl[12] = '{6'b100011, 1'b0, 6'b000000, 14'b00011011_01_0001};
        tbl[13] = '{6'b101011, 1'b0, 6'b000000, 14'b00000101_01_0001};
        tbl[14] = '{6'b000100, 1'b0, 6'b000000, 14'b00100000_01_0010};
        tbl[15] = '{6'b000010, 1'b0, 6'b000000, 14'b10000000_00_0000};
        tbl[16] = '{6'b111111, 1'b1, 6'b111111, 14'b0}; // never matches a real row usefully
    end

    function automatic logic [13:0] model_dec(input logic [5:0] op, input logic [5:0] fn);
        logic [13:0] r = '0;
        for (int i = 0; i < 16; i++)
            if (tbl[i].op == op && (!tbl[i].use_fn || tbl[i].fn == fn)) r = tbl[i].bits;
        return r;
    endfunction

    function automatic logic [31:0] model_ext(input logic [1:0] mode, input logic [15:0] v);
        int unsigned u;
        u = v;
        if (mode == 2'b01 && v[15]) u = u + 32'hFFFF0000;
        else if (mode == 2'b10) u = u * 65536;
        return u;
    endfunction

    // Expected EX/MEM contents after the most recent edge.
    logic [29:0] e_pc;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_sd;
    logic        e_zero;
    logic [5:0]  e_ctrl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [13:0] d;
        d = model_dec(opcode, funct);
        chk("decode", {c_jump, c_reg_dst, c_branch, c_mem_read, c_mem_to_reg, c_mem_write,
                       c_reg_write, c_alu_src, ext_op, alu_op}, d);
        chk("imm32", imm32, model_ext(d[5:4], imm16));
        chk("pc", pc, e_pc);
        chk("reg_dst", reg_dst, e_rd);
        chk("alu_result", alu_result, e_alu);
        chk("zero", zero, e_zero);
        chk("store_data", store_data, e_sd);
        chk("ctrl", ctrl, e_ctrl);
        chk("pc_go", pc_go, (e_ctrl[5] == 1'b1) || (e_ctrl[4] == 1'b1 && e_zero == 1'b1));
    endtask

    // One clock: the model takes the inputs as they stand, then outputs are sampled mid-cycle.
    task automatic tick();
        logic [29:0] n_pc;  logic [4:0] n_rd; logic [31:0] n_alu, n_sd; logic n_zero; logic [5:0] n_ctrl;
        if (rst || flush) begin
            n_pc = 0; n_rd = 0; n_alu = 0; n_sd = 0; n_zero = 0; n_ctrl = 0;
        end else if (wr) begin
            n_pc = in_pc; n_rd = in_reg_dst; n_alu = in_alu_result; n_sd = in_store_data;
            n_zero = in_zero; n_ctrl = in_ctrl;
        end else begin
            n_pc = e_pc; n_rd = e_rd; n_alu = e_alu; n_sd = e_sd; n_zero = e_zero; n_ctrl = e_ctrl;
        end
        @(posedge clk);
        e_pc = n_pc; e_rd = n_rd; e_alu = n_alu; e_sd = n_sd; e_zero = n_zero; e_ctrl = n_ctrl;
        @(negedge clk);
        check_all();
    endtask

    logic [5:0] ops [10];
    logic [5:0] fns [8];

    initial begin
        ops = '{6'b000000, 6'b001000, 6'b001001, 6'b001100, 6'b001101,
                6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

        // Reset with nonzero inputs.
        rst = 1; flush = 0; wr = 1;
        opcode = 0; funct = 0; imm16 = 16'hBEEF;
        in_pc = 30'h3ABCDEF; in_reg_dst = 5'd17; in_alu_result = 32'hDEADBEEF; in_zero = 1;
        in_store_data = 32'hCAFEF00D; in_ctrl = 6'b111111;
        e_pc = 'x; e_rd = 'x; e_alu = 'x; e_sd = 'x; e_zero = 'x; e_ctrl = 'x;
        tick();
        chk("rst_pc_lit", pc, 0);
        chk("rst_ctrl_lit", ctrl, 0);
        chk("rst_alu_lit", alu_result, 0);
        chk("rst_pcgo_lit", pc_go, 0);

        rst = 0; wr = 1; in_pc = 30'h0000010; in_ctrl = 6'b010000; in_zero = 1;
        tick();
        chk("rel_pc_lit", pc, 30'h10);
        chk("rel_pcgo_lit", pc_go, 1);

        // Decode sweep against literals.
        opcode = 6'b100011; funct = 6'b000000; #1;
        chk("lw_ctl_lit", {c_mem_read, c_mem_to_reg, c_reg_write, c_alu_src, c_mem_write, c_jump, c_branch, c_reg_dst}, 8'b1111_0000);
        chk("lw_ext_lit", ext_op, 2'b01);
        chk("lw_alu_lit", alu_op, 4'd1);
        opcode = 6'b000000; funct = 6'b101010; #1;
        chk("slt_ctl_lit", {c_reg_dst, c_reg_write, c_alu_src, c_mem_read}, 4'b1100);
        chk("slt_alu_lit", alu_op, 4'd5);
        opcode = 6'b000000; funct = 6'b000000; imm16 = 16'h0000; #1;
        chk("nop_lit", {c_jump, c_reg_dst, c_branch, c_mem_read, c_mem_to_reg, c_mem_write,
                        c_reg_write, c_alu_src, ext_op, alu_op}, 14'b0);
        opcode = 6'b111111; funct = 6'b100000; #1;
        chk("bad_op_lit", {c_jump, c_reg_dst, c_branch, c_mem_read, c_mem_to_reg, c_mem_write,
                           c_reg_write, c_alu_src, ext_op, alu_op}, 14'b0);

        // Extender literals.
        opcode = 6'b001000; imm16 = 16'h8001; #1;
        chk("addi_imm_lit", imm32, 32'hFFFF8001);
        opcode = 6'b001101; #1;
        chk("ori_imm_lit", imm32, 32'h00008001);
        opcode = 6'b001111; imm16 = 16'h1234; #1;
        chk("lui_imm_lit", imm32, 32'h12340000);

        // Flush beats write.
        flush = 1; wr = 1; in_ctrl = 6'b000001;
        tick();
        chk("flush_ctrl_lit", ctrl, 6'b000000);
        flush = 0;
        tick();
        chk("wr_ctrl_lit", ctrl, 6'b000001);
        chk("wr_regwr_lit", ctrl[0], 1);

        // Hold.
        in_alu_result = 32'hAAAA5555;
        tick();
        wr = 0; in_alu_result = 32'h12345678;
        tick();
        chk("hold_alu_lit", alu_result, 32'hAAAA5555);

        // Jump / branch redirect.
        wr = 1; in_ctrl = 6'b100000; in_zero = 0;
        tick();
        chk("jump_pcgo_lit", pc_go, 1);
        in_ctrl = 6'b010000; in_zero = 0;
        tick();
        chk("beq_nt_pcgo_lit", pc_go, 0);

        // Randomized run.
        for (int n = 0; n < 500; n++) begin
            rst   = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 9) == 0);
            wr    = $urandom_range(0, 1);
            opcode = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            funct  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            imm16  = 16'($urandom);
            in_pc = 30'($urandom); in_reg_dst = 5'($urandom); in_alu_result = $urandom;
            in_zero = 1'($urandom); in_store_data = $urandom; in_ctrl = 6'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_ext_exmem.md
Name: ctrl_ext_exmem

Overview:
- Groups three pieces of the 5-stage MIPS pipeline:
  - the ID-stage main/ALU control decoder;
  - the ID-stage 16→32 immediate extender;
  - the EX/MEM pipeline register.
- Decoder and extender are purely combinational. The EX/MEM register is the only state.
- The registered branch/jump outputs feed the IF-stage PC mux (redirect taken from MEM stage).

Parameters:
- PC_W, 30, width of word-addressed PC field (byte address bits [31:2]).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset of EX/MEM register.
- flush  in  1  synchronous clear of EX/MEM register (control-hazard squash).
- wr  in  1  EX/MEM load enable.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- imm16  in  16  instr[15:0].
- c_jump, c_reg_dst, c_branch, c_mem_read, c_mem_to_reg, c_mem_write, c_reg_write, c_alu_src  out  1 each  decoded controls.
- ext_op  out  2  extender mode, also used internally.
- alu_op  out  4  ALU operation code.
- imm32  out  32  extended immediate.
- in_pc  in  PC_W  branch/jump target from EX.
- in_reg_dst  in  5  destination register.
- in_alu_result  in  32  ALU result.
- in_zero  in  1  ALU zero flag.
- in_store_data  in  32  forwarded rt value for sw.
- in_ctrl  in  6  {jump, branch, mem_read, mem_to_reg, mem_write, reg_write}.
- pc, reg_dst, alu_result, zero, store_data, ctrl  out  (same widths)  registered copies.
- pc_go  out  1  (ctrl[4] & zero) | ctrl[5].

Behaviour:
- ext_op encoding:
  - 00 zero-extend;
  - 01 sign-extend;
  - 10 upper: imm16 placed in bits [31:16], lower 16 bits zero;
  - 11 zero-extend.
- alu_op encoding: 0 NOP(out 0), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT.
- Decoder truth (controls not listed are 0; ext_op defaults 00; alu_op defaults NOP):
  - R-type (op 000000):
    - reg_dst=1 and reg_write=1 for add/addu (100000/100001)→ADD, sub/subu (100010/100011)→SUB, and (100100)→AND, or (100101)→OR, slt (101010)→SLT.
    - Any other funct, including 000000 (nop/sll), decodes to all-zero.
  - addi 001000 / addiu 001001: reg_write, alu_src, ext 01, ADD.
  - andi 001100: reg_write, alu_src, ext 00, AND.
  - ori 001101: reg_write, alu_src, ext 00, OR.
  - lui 001111: reg_write, alu_src, ext 10, ADD (rs=$0).
  - lw 100011: mem_read, mem_to_reg, reg_write, alu_src, ext 01, ADD.
  - sw 101011: mem_write, alu_src, ext 01, ADD.
  - beq 000100: branch, ext 01, SUB.
  - j 000010: jump, ext 00, NOP.
  - Any other opcode: all outputs 0.
- Extender: imm32 follows ext_op combinationally, zero latency.
- EX/MEM register, at posedge clk, priority order:
  - rst=1: all registered outputs ← 0.
  - else flush=1: all ← 0.
  - else wr=1: all ← corresponding in_*.
  - else hold.
- Flush and reset give identical state (bubble: no reg_write, no mem_write, pc_go=0).
- Latency: one cycle from in_* to outputs. pc_go is combinational from registered fields only.
- in_pc is passed through unchanged. Width truncation of target arithmetic is the caller's responsibility.

Decomposition:
- Package ctrl_pkg holds:
  - opcode/funct localparams;
  - the ext_op and alu_op encodings;
  - in_ctrl bit indices.
- One sub-module is natural: exmem_reg (the clocked register). Decoder and extender stay as combinational always blocks in the top.

Test Plan:
- Reset: drive in_* nonzero, rst=1, one edge → all outputs 0, pc_go=0. Release rst with wr=1, in_pc=0x0000010, in_ctrl=6'b010000, in_zero=1 → next edge: pc=0x10, pc_go=1.
- Decode sweep:
  - opcode 100011 → mem_read=mem_to_reg=reg_write=alu_src=1, ext_op=01, alu_op=1.
  - opcode 000000 with funct 101010 → reg_dst=reg_write=1, alu_op=5.
  - instruction word 0x00000000 → all controls 0.
  - opcode 111111 → all controls 0.
- Extender:
  - imm16=0x8001 with opcode addi → imm32=0xFFFF8001.
  - same imm16 with ori → 0x00008001.
  - lui with imm16=0x1234 → 0x12340000.
- Flush vs write:
  - flush=1 and wr=1 with in_ctrl=6'b000001 → ctrl=0 after edge.
  - Next cycle flush=0 → ctrl=000001, reg_write=1.
- Hold: wr=0 while in_alu_result changes 0xAAAA5555→0x12345678 → alu_result stays at prior value.
- Jump/branch: registered ctrl=6'b100000 → pc_go=1 regardless of zero. Registered ctrl=6'b010000 with zero=0 → pc_go=0.
